// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 8-bit ALU with CCR, branch resolution,
// execute/memory pipeline register and the processor halt state machine.
module ex_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic [1:0] ra,
   input  logic [1:0] rb,
   input  logic [7:0] R_ra,
   input  logic [7:0] R_rb,
   input  logic       RW,
   input  logic       SW1,
   input  logic       SW2,
   input  logic       out_ld,
   input  logic       MW,
   input  logic       SM2,
   input  logic       SE2,
   input  logic [1:0] SP,
   input  logic [1:0] SE3,
   input  logic [3:0] ALU,
   input  logic [4:0] Flags,
   input  logic [2:0] BU,
   input  logic       Hlt,
   input  logic [1:0] has_hazard,
   output logic [1:0] em_ra,
   output logic [1:0] em_rb,
   output logic       em_RW,
   output logic [1:0] em_SP,
   output logic       em_SW1,
   output logic       em_SW2,
   output logic       em_out_ld,
   output logic       em_MW,
   output logic       em_SM2,
   output logic       em_SE2,
   output logic [1:0] em_SE3,
   output logic [7:0] em_result,
   output logic [7:0] em_B,
   output logic [3:0] ccr,
   output logic       branch_taken,
   output logic [7:0] branch_target,
   output logic       halted
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

   typedef struct packed {
      logic [1:0] ra;
      logic [1:0] rb;
      logic       rw;
      logic [1:0] sp;
      logic       sw1;
      logic       sw2;
      logic       out_ld;
      logic       mw;
      logic       sm2;
      logic       se2;
      logic [1:0] se3;
      logic [7:0] result;
      logic [7:0] b;
   } em_t;

   state_e     state_q, state_d;
   em_t        em_q, em_d;
   logic [3:0] ccr_q, ccr_d;
   logic [7:0] op_a, op_b;
   logic [7:0] alu_res;
   logic       alu_c, alu_v, br_cond;

   // Returns {overflow, carry/borrow, result[7:0]}
   function automatic logic [9:0] arith(input logic [7:0] x, input logic [7:0] y, input logic sub);
      logic [8:0] s;
      logic       v;
      if (sub) begin
         s = {1'b0, x} - {1'b0, y};
         v = (x[7] != y[7]) && (s[7] != x[7]);
      end else begin
         s = {1'b0, x} + {1'b0, y};
         v = (x[7] == y[7]) && (s[7] != x[7]);
      end
      return {v, s};
   endfunction

   assign op_a = has_hazard[0] ? em_q.result : R_ra;
   assign op_b = has_hazard[1] ? em_q.result : R_rb;

   always_comb begin
      alu_res = op_b;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ALU)
         4'd0:  alu_res = op_b;
         4'd1:  {alu_v, alu_c, alu_res} = arith(op_a, op_b, 1'b0);
         4'd2:  {alu_v, alu_c, alu_res} = arith(op_a, op_b, 1'b1);
         4'd3:  alu_res = op_a & op_b;
         4'd4:  alu_res = op_a | op_b;
         4'd5:  alu_res = op_a ^ op_b;
         4'd6:  {alu_v, alu_c, alu_res} = arith(8'hFF, op_b, 1'b1);
         4'd7:  {alu_v, alu_c, alu_res} = arith(8'h00, op_b, 1'b1);
         4'd8:  {alu_v, alu_c, alu_res} = arith(op_b, 8'h01, 1'b0);
         4'd9:  {alu_v, alu_c, alu_res} = arith(op_b, 8'h01, 1'b1);
         4'd10: begin alu_res = {op_b[6:0], ccr_q[2]}; alu_c = op_b[7]; end
         4'd11: begin alu_res = {ccr_q[2], op_b[7:1]}; alu_c = op_b[0]; end
         4'd12: begin alu_res = op_b; alu_c = 1'b1; end
         4'd13: begin alu_res = op_b; alu_c = 1'b0; end
         default: alu_res = op_a;
      endcase
   end

   // Conditional branches look at the CCR before this instruction's update
   always_comb begin
      br_cond = 1'b0;
      case (BU)
         3'd1:    br_cond = ccr_q[0];
         3'd2:    br_cond = ccr_q[1];
         3'd3:    br_cond = ccr_q[2];
         3'd4:    br_cond = ccr_q[3];
         3'd5,
         3'd6:    br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
   end

   assign branch_taken  = br_cond && !stall && (state_q == RUN);
   assign branch_target = op_b;

   always_comb begin
      state_d = state_q;
      if (state_q == RUN && Hlt && !stall) state_d = HALTED;
   end

   // A halt instruction and every cycle spent halted load a bubble and leave the CCR alone
   always_comb begin
      em_d  = '0;
      ccr_d = ccr_q;
      if (state_q == RUN && !Hlt) begin
         em_d.ra     = ra;
         em_d.rb     = rb;
         em_d.rw     = RW;
         em_d.sp     = SP;
         em_d.sw1    = SW1;
         em_d.sw2    = SW2;
         em_d.out_ld = out_ld;
         em_d.mw     = MW;
         em_d.sm2    = SM2;
         em_d.se2    = SE2;
         em_d.se3    = SE3;
         em_d.result = alu_res;
         em_d.b      = op_b;
         if (Flags[4]) begin
            ccr_d = op_b[3:0];
         end else begin
            if (Flags[0]) ccr_d[0] = (alu_res == 8'h00);
            if (Flags[1]) ccr_d[1] = alu_res[7];
            if (Flags[2]) ccr_d[2] = alu_c;
            if (Flags[3]) ccr_d[3] = alu_v;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         em_q    <= '0;
         ccr_q   <= '0;
      end else if (!stall) begin
         state_q <= state_d;
         em_q    <= em_d;
         ccr_q   <= ccr_d;
      end
   end

   assign em_ra     = em_q.ra;
   assign em_rb     = em_q.rb;
   assign em_RW     = em_q.rw;
   assign em_SP     = em_q.sp;
   assign em_SW1    = em_q.sw1;
   assign em_SW2    = em_q.sw2;
   assign em_out_ld = em_q.out_ld;
   assign em_MW     = em_q.mw;
   assign em_SM2    = em_q.sm2;
   assign em_SE2    = em_q.se2;
   assign em_SE3    = em_q.se3;
   assign em_result = em_q.result;
   assign em_B      = em_q.b;
   assign ccr       = ccr_q;
   assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: random and directed instructions checked against an
// arithmetic reference model through an expected-value scoreboard.
module tb_ex_stage;

   typedef struct packed {
      logic       reset;
      logic       stall;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [7:0] R_ra;
      logic [7:0] R_rb;
      logic       RW;
      logic       SW1;
      logic       SW2;
      logic       out_ld;
      logic       MW;
      logic       SM2;
      logic       SE2;
      logic [1:0] SP;
      logic [1:0] SE3;
      logic [3:0] ALU;
      logic [4:0] Flags;
      logic [2:0] BU;
      logic       Hlt;
      logic [1:0] has_hazard;
   } stim_t;

   // Registered view of the stage, in the order the monitor packs it
   typedef struct packed {
      logic [1:0] ra;
      logic [1:0] rb;
      logic       rw;
      logic [1:0] sp;
      logic       sw1;
      logic       sw2;
      logic       out_ld;
      logic       mw;
      logic       sm2;
      logic       se2;
      logic [1:0] se3;
      logic [7:0] result;
      logic [7:0] b;
      logic [3:0] ccr;
      logic       halted;
   } exp_t;

   localparam int EW = $bits(exp_t);

   logic       clk;
   logic       reset, stall, RW, SW1, SW2, out_ld, MW, SM2, SE2, Hlt;
   logic [1:0] ra, rb, SP, SE3, has_hazard;
   logic [7:0] R_ra, R_rb;
   logic [3:0] ALU;
   logic [4:0] Flags;
   logic [2:0] BU;
   logic [1:0] em_ra, em_rb, em_SP, em_SE3;
   logic       em_RW, em_SW1, em_SW2, em_out_ld, em_MW, em_SM2, em_SE2;
   logic [7:0] em_result, em_B, branch_target;
   logic [3:0] ccr;
   logic       branch_taken, halted;

   logic [EW-1:0] exp_q[$];
   logic [8:0]    bt_q[$];
   int            errors = 0;
   int            checks = 0;

   exp_t  m;
   stim_t s;

   ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .ra(ra), .rb(rb),
      .R_ra(R_ra), .R_rb(R_rb), .RW(RW), .SW1(SW1), .SW2(SW2),
      .out_ld(out_ld), .MW(MW), .SM2(SM2), .SE2(SE2), .SP(SP), .SE3(SE3),
      .ALU(ALU), .Flags(Flags), .BU(BU), .Hlt(Hlt), .has_hazard(has_hazard),
      .em_ra(em_ra), .em_rb(em_rb), .em_RW(em_RW), .em_SP(em_SP),
      .em_SW1(em_SW1), .em_SW2(em_SW2), .em_out_ld(em_out_ld), .em_MW(em_MW),
      .em_SM2(em_SM2), .em_SE2(em_SE2), .em_SE3(em_SE3),
      .em_result(em_result), .em_B(em_B), .ccr(ccr),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .halted(halted)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sgn(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   // Reference model: one instruction's effect, from the stage's architectural rules
   task automatic model_step(input stim_t t);
      int a, b, r, c, v, sa, sb, cin;
      logic [7:0] r8;
      logic       taken;
      a   = t.has_hazard[0] ? int'(m.result) : int'(t.R_ra);
      b   = t.has_hazard[1] ? int'(m.result) : int'(t.R_rb);
      sa  = sgn(a);
      sb  = sgn(b);
      cin = int'(m.ccr[2]);
      case (t.BU)
         3'd1: taken = m.ccr[0];
         3'd2: taken = m.ccr[1];
         3'd3: taken = m.ccr[2];
         3'd4: taken = m.ccr[3];
         3'd5, 3'd6: taken = 1'b1;
         default: taken = 1'b0;
      endcase
      taken = taken && !t.stall && !m.halted;
      bt_q.push_back({taken, 8'(b)});

      if (t.reset) begin
         m = '0;
      end else if (t.stall) begin
         m = m;
      end else if (m.halted || t.Hlt) begin
         m.ra = 0; m.rb = 0; m.rw = 0; m.sp = 0; m.sw1 = 0; m.sw2 = 0;
         m.out_ld = 0; m.mw = 0; m.sm2 = 0; m.se2 = 0; m.se3 = 0;
         m.result = 0; m.b = 0;
         m.halted = 1'b1;
      end else begin
         c = 0; v = 0;
         case (t.ALU)
            4'd0:  r = b;
            4'd1:  begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd2:  begin r = a - b; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = 255 - b;
            4'd7:  begin r = -b; c = (b != 0); v = (b == 128); end
            4'd8:  begin r = b + 1; c = (b == 255); v = (b == 127); end
            4'd9:  begin r = b - 1; c = (b == 0); v = (b == 128); end
            4'd10: begin r = b * 2 + cin; c = (b >= 128); end
            4'd11: begin r = b / 2 + cin * 128; c = b % 2; end
            4'd12: begin r = b; c = 1; end
            4'd13: begin r = b; c = 0; end
            default: r = a;
         endcase
         r8 = 8'(r);
         if (t.Flags[4]) begin
            m.ccr = 4'(b);
         end else begin
            if (t.Flags[0]) m.ccr[0] = (r8 == 8'h00);
            if (t.Flags[1]) m.ccr[1] = r8[7];
            if (t.Flags[2]) m.ccr[2] = (c != 0);
            if (t.Flags[3]) m.ccr[3] = (v != 0);
         end
         m.ra = t.ra; m.rb = t.rb; m.rw = t.RW; m.sp = t.SP;
         m.sw1 = t.SW1; m.sw2 = t.SW2; m.out_ld = t.out_ld; m.mw = t.MW;
         m.sm2 = t.SM2; m.se2 = t.SE2; m.se3 = t.SE3;
         m.result = r8;
         m.b = 8'(b);
      end
      exp_q.push_back(m);
   endtask

   // driver: one instruction per clock, applied just after the rising edge
   task automatic drive(input stim_t t);
      @(posedge clk);
      #1;
      reset = t.reset; stall = t.stall; ra = t.ra; rb = t.rb;
      R_ra = t.R_ra; R_rb = t.R_rb; RW = t.RW; SW1 = t.SW1; SW2 = t.SW2;
      out_ld = t.out_ld; MW = t.MW; SM2 = t.SM2; SE2 = t.SE2; SP = t.SP;
      SE3 = t.SE3; ALU = t.ALU; Flags = t.Flags; BU = t.BU; Hlt = t.Hlt;
      has_hazard = t.has_hazard;
      model_step(t);
   endtask

   function automatic stim_t rand_stim();
      stim_t t;
      t            = stim_t'({$urandom, $urandom, $urandom});
      t.reset      = ($urandom_range(0, 29) == 0);
      t.stall      = ($urandom_range(0, 7) == 0);
      t.Hlt        = ($urandom_range(0, 39) == 0);
      t.has_hazard = 2'($urandom_range(0, 3));
      t.Flags      = ($urandom_range(0, 5) == 0) ? 5'h10 : {1'b0, 4'($urandom)};
      return t;
   endfunction

   // scoreboard monitor: registered outputs of the previous edge, branch outputs of the current inputs
   initial begin
      int   n;
      exp_t e;
      exp_t g;
      logic [8:0] eb;
      forever begin
         @(posedge clk);
         n = exp_q.size();
         @(negedge clk);
         if (n > 0) begin
            e = exp_q.pop_front();
            g = {em_ra, em_rb, em_RW, em_SP, em_SW1, em_SW2, em_out_ld, em_MW,
                 em_SM2, em_SE2, em_SE3, em_result, em_B, ccr, halted};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL regs t=%0t got=%h exp=%h (result %h/%h ccr %h/%h halted %b/%b)",
                        $time, g, e, g.result, e.result, g.ccr, e.ccr, g.halted, e.halted);
            end
         end
         if (bt_q.size() > 0) begin
            eb = bt_q.pop_front();
            checks++;
            if ({branch_taken, branch_target} !== eb) begin
               errors++;
               $display("FAIL branch t=%0t got taken=%b target=%h exp taken=%b target=%h",
                        $time, branch_taken, branch_target, eb[8], eb[7:0]);
            end
         end
      end
   end

   initial begin
      m = '0;
      s = '0;
      s.reset = 1'b1;
      {reset, stall, ra, rb, R_ra, R_rb, RW, SW1, SW2, out_ld, MW, SM2, SE2,
       SP, SE3, ALU, Flags, BU, Hlt, has_hazard} = s;
      drive(s);
      drive(s);
      s = '0;
      drive(s);
      // overflow into the sign bit
      s.ALU = 4'd1; s.R_ra = 8'h7F; s.R_rb = 8'h01; s.Flags = 5'h0F;
      drive(s);
      // wrap-around to zero with carry
      s.R_ra = 8'hFF;
      drive(s);
      // forwarding of the held result into operand A
      s = '0; s.R_rb = 8'h10;
      drive(s);
      s.ALU = 4'd2; s.has_hazard = 2'b01; s.R_ra = 8'h00; s.Flags = 5'h0F;
      drive(s);
      // JZ taken with Z=1, then cleared Z, then JZ not taken and JMP taken
      s = '0; s.BU = 3'd1; s.R_rb = 8'h42;
      drive(s);
      s = '0; s.ALU = 4'd0; s.R_rb = 8'h05; s.Flags = 5'h01;
      drive(s);
      s = '0; s.BU = 3'd1; s.R_rb = 8'h42;
      drive(s);
      s.BU = 3'd5; s.RW = 1'b1;
      drive(s);
      // stall for three cycles with a pending ADD and a branch, then release
      s = '0; s.stall = 1'b1; s.ALU = 4'd1; s.R_ra = 8'h33; s.R_rb = 8'h44;
      s.Flags = 5'h0F; s.BU = 3'd5;
      repeat (3) drive(s);
      s.stall = 1'b0; s.BU = 3'd0;
      drive(s);
      // CCR restore, then Z-only update
      s = '0; s.Flags = 5'h10; s.R_rb = 8'h0A;
      drive(s);
      s = '0; s.ALU = 4'd4; s.R_ra = 8'h01; s.R_rb = 8'h80; s.Flags = 5'h01;
      drive(s);
      // halt, ignored instructions while halted, reset releases
      s = '0; s.Hlt = 1'b1; s.RW = 1'b1; s.ALU = 4'd1; s.R_ra = 8'h01; s.Flags = 5'h0F;
      drive(s);
      s = '0; s.RW = 1'b1; s.MW = 1'b1; s.ALU = 4'd0; s.R_rb = 8'h77; s.Flags = 5'h0F; s.BU = 3'd5;
      repeat (2) drive(s);
      s.reset = 1'b1;
      drive(s);
      s.reset = 1'b0; s.BU = 3'd0;
      drive(s);
      // randomized instruction stream
      for (int i = 0; i < 600; i++) drive(rand_stim());
      s = '0;
      repeat (3) drive(s);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
